// File: rtl/red_pitaya_hk_ext.sv
// Housekeeping slot: board ID, device DNA readout, LEDs with per-bit blink,
// expansion GPIO with synchronised inputs and sticky rising-edge flags, loopback bit.

// Behavioural stand-in for the DNA_PORT primitive, advanced on each dna_clk rising edge.
module red_pitaya_hk_ext_dna #(
  parameter logic [56:0] DNA = 57'h0823456789ABCDE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_ce,
  input  logic i_read,
  input  logic i_shift,
  input  logic i_din,
  output logic o_dout
);
  logic [56:0] r_sr;

  always_ff @(posedge clk_i) begin
    if (rst_i)        r_sr <= '0;
    else if (i_ce) begin
      if (i_read)       r_sr <= DNA;
      else if (i_shift) r_sr <= {r_sr[55:0], i_din};
    end
  end

  assign o_dout = r_sr[56];
endmodule

module red_pitaya_hk_ext #(
  parameter int          DWL      = 8,
  parameter int          DWE      = 8,
  parameter logic [56:0] DNA      = 57'h0823456789ABCDE,
  parameter logic [3:0]  BOARD_ID = 4'h1,
  parameter logic [7:0]  HK_REV   = 8'h02,
  parameter int          DNA_DIV  = 4,
  parameter int          BLINK_W  = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [DWL-1:0] led_o,
  output logic           digital_loop,
  input  logic [DWE-1:0] exp_p_dat_i,
  input  logic [DWE-1:0] exp_n_dat_i,
  output logic [DWE-1:0] exp_p_dat_o,
  output logic [DWE-1:0] exp_n_dat_o,
  output logic [DWE-1:0] exp_p_dir_o,
  output logic [DWE-1:0] exp_n_dir_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic [3:0]     sys_sel,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);
  localparam int DIV_W = (DNA_DIV > 1) ? $clog2(DNA_DIV) : 1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} dna_st_t;

  logic [19:0]        w_addr;
  logic               w_acc, w_hit, w_restart, w_wr_per, w_tick, w_last, w_dna_rise, w_dna_dout;
  logic [31:0]        w_rd;
  logic [DWE-1:0]     w_clr_p, w_clr_n;
  logic               w_unused;

  logic               r_loop, r_phase, r_ack, r_err;
  logic [31:0]        r_rdata;
  logic [DWE-1:0]     r_dir_p, r_dir_n, r_dat_p, r_dat_n;
  logic [DWE-1:0]     r_s1_p, r_s2_p, r_s3_p, r_s1_n, r_s2_n, r_s3_n, r_stk_p, r_stk_n;
  logic [DWL-1:0]     r_led, r_mask;
  logic [BLINK_W-1:0] r_per, r_bcnt;
  dna_st_t            r_state;
  logic [DIV_W-1:0]   r_div;
  logic               r_dna_clk, r_dna_read, r_dna_shift, r_dna_done;
  logic [5:0]         r_bits;
  logic [56:0]        r_dna_value;

  assign w_addr    = sys_addr[19:0];
  assign w_acc     = sys_wen | sys_ren;
  assign w_restart = sys_wen && (w_addr == 20'h0C) && sys_wdata[1];
  assign w_wr_per  = sys_wen && (w_addr == 20'h38);
  assign w_clr_p   = (sys_wen && (w_addr == 20'h28)) ? sys_wdata[DWE-1:0] : '0;
  assign w_clr_n   = (sys_wen && (w_addr == 20'h2C)) ? sys_wdata[DWE-1:0] : '0;
  assign w_unused  = ^{sys_sel, sys_addr[31:20], sys_wdata};

  // DNA readout: ticks at divider wrap; the last capture in SHIFT suppresses the next rising edge.
  assign w_tick     = (r_div == DIV_W'(DNA_DIV - 1));
  assign w_last     = (r_bits == 6'd56);
  assign w_dna_rise = w_tick & ~r_dna_clk & ~w_restart &
                      ((r_state == S_LOAD) | ((r_state == S_SHIFT) & ~w_last));

  red_pitaya_hk_ext_dna #(.DNA(DNA)) u_dna (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_ce    (w_dna_rise),
    .i_read  (r_dna_read),
    .i_shift (r_dna_shift),
    .i_din   (1'b0),
    .o_dout  (w_dna_dout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || w_restart) begin
      r_state     <= S_LOAD;
      r_div       <= '0;
      r_dna_clk   <= 1'b0;
      r_dna_read  <= 1'b1;
      r_dna_shift <= 1'b0;
      r_bits      <= '0;
      r_dna_value <= '0;
      r_dna_done  <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      case (r_state)
        S_LOAD: if (w_tick) begin
          r_dna_clk <= ~r_dna_clk;
          if (r_dna_clk) begin
            r_state     <= S_SHIFT;
            r_dna_read  <= 1'b0;
            r_dna_shift <= 1'b1;
          end
        end
        S_SHIFT: if (w_tick) begin
          if (!r_dna_clk) begin
            r_dna_value <= {r_dna_value[55:0], w_dna_dout};
            r_bits      <= r_bits + 6'd1;
            if (w_last) begin
              r_state     <= S_DONE;
              r_dna_shift <= 1'b0;
              r_dna_done  <= 1'b1;
            end else begin
              r_dna_clk <= 1'b1;
            end
          end else begin
            r_dna_clk <= 1'b0;
          end
        end
        S_DONE: ;
        default: begin
          r_state    <= S_LOAD;
          r_dna_read <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_loop <= 1'b0;
      r_dir_p <= '0; r_dir_n <= '0; r_dat_p <= '0; r_dat_n <= '0;
      r_led <= '0; r_mask <= '0; r_per <= '0;
    end else if (sys_wen) begin
      case (w_addr)
        20'h0C: r_loop  <= sys_wdata[0];
        20'h10: r_dir_p <= sys_wdata[DWE-1:0];
        20'h14: r_dir_n <= sys_wdata[DWE-1:0];
        20'h18: r_dat_p <= sys_wdata[DWE-1:0];
        20'h1C: r_dat_n <= sys_wdata[DWE-1:0];
        20'h30: r_led   <= sys_wdata[DWL-1:0];
        20'h34: r_mask  <= sys_wdata[DWL-1:0];
        20'h38: r_per   <= sys_wdata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_wr_per || (r_per == '0)) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == r_per - BLINK_W'(1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt <= r_bcnt + BLINK_W'(1);
    end
  end

  // Set term is OR-ed after the clear so a coincident edge keeps the flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_p <= '0; r_s2_p <= '0; r_s3_p <= '0; r_stk_p <= '0;
      r_s1_n <= '0; r_s2_n <= '0; r_s3_n <= '0; r_stk_n <= '0;
    end else begin
      r_s1_p <= exp_p_dat_i; r_s2_p <= r_s1_p; r_s3_p <= r_s2_p;
      r_s1_n <= exp_n_dat_i; r_s2_n <= r_s1_n; r_s3_n <= r_s2_n;
      r_stk_p <= (r_stk_p & ~w_clr_p) | (r_s2_p & ~r_s3_p);
      r_stk_n <= (r_stk_n & ~w_clr_n) | (r_s2_n & ~r_s3_n);
    end
  end

  always_comb begin
    w_hit = 1'b1;
    w_rd  = '0;
    case (w_addr)
      20'h00: w_rd = {16'h0, HK_REV, 4'h0, BOARD_ID};
      20'h04: w_rd = r_dna_value[31:0];
      20'h08: w_rd = {r_dna_done, 6'h0, r_dna_value[56:32]};
      20'h0C: w_rd = {31'h0, r_loop};
      20'h10: w_rd = 32'(r_dir_p);
      20'h14: w_rd = 32'(r_dir_n);
      20'h18: w_rd = 32'(r_dat_p);
      20'h1C: w_rd = 32'(r_dat_n);
      20'h20: w_rd = 32'(r_s2_p);
      20'h24: w_rd = 32'(r_s2_n);
      20'h28: w_rd = 32'(r_stk_p);
      20'h2C: w_rd = 32'(r_stk_n);
      20'h30: w_rd = 32'(r_led);
      20'h34: w_rd = 32'(r_mask);
      20'h38: w_rd = 32'(r_per);
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_acc;
      r_err   <= w_acc & ~w_hit;
      r_rdata <= w_acc ? w_rd : '0;
    end
  end

  assign led_o        = r_led ^ (r_mask & {DWL{r_phase}});
  assign digital_loop = r_loop;
  assign exp_p_dir_o  = r_dir_p;
  assign exp_n_dir_o  = r_dir_n;
  assign exp_p_dat_o  = r_dat_p;
  assign exp_n_dat_o  = r_dat_n;
  assign sys_rdata    = r_rdata;
  assign sys_err      = r_err;
  assign sys_ack      = r_ack;
endmodule

// File: tb/tb_red_pitaya_hk_ext.sv
// Randomised bench for red_pitaya_hk_ext against a register-map / timing model.
module tb_red_pitaya_hk_ext;
  localparam logic [56:0] DNA_V  = 57'h0823456789ABCDE;
  localparam logic [31:0] DNA_LO = DNA_V[31:0];
  localparam logic [31:0] DNA_HI = {1'b1, 6'h0, DNA_V[56:32]};

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  led_o, exp_p_dat_o, exp_n_dat_o, exp_p_dir_o, exp_n_dir_o;
  logic [7:0]  exp_p_dat_i = '0, exp_n_dat_i = '0;
  logic        digital_loop, sys_err, sys_ack;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic [3:0]  sys_sel = 4'hF;
  logic        sys_wen = 1'b0, sys_ren = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0, n_bad = 0;

  red_pitaya_hk_ext dut (
    .clk_i(clk), .rst_i(rst), .led_o(led_o), .digital_loop(digital_loop),
    .exp_p_dat_i(exp_p_dat_i), .exp_n_dat_i(exp_n_dat_i),
    .exp_p_dat_o(exp_p_dat_o), .exp_n_dat_o(exp_n_dat_o),
    .exp_p_dir_o(exp_p_dir_o), .exp_n_dir_o(exp_n_dir_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: strobe for one cycle, response sampled in the following cycle.
  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output logic ak);
    @(posedge clk); #1;
    sys_addr = a; sys_wdata = d; sys_wen = wr; sys_ren = ~wr;
    @(posedge clk); #1;
    sys_wen = 1'b0; sys_ren = 1'b0;
    rd = sys_rdata; er = sys_err; ak = sys_ack;
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; logic e, k;
    bus(1'b1, a, d, r, e, k);
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] r);
    logic e, k;
    bus(1'b0, a, 32'h0, r, e, k);
  endtask

  task automatic do_reset(output int unsigned t_rel);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    t_rel = cyc;
  endtask

  // Poll the DNA-high register until done, bounded by a cycle budget from t0.
  task automatic wait_dna(input string tag, input int unsigned t0, input int budget);
    logic [31:0] r;
    bit ok = 0;
    while (int'(cyc - t0) < budget) begin
      rd32(32'h08, r);
      if (r[31]) begin ok = 1; break; end
    end
    chk({tag, "_done_in_time"}, 32'(ok), 32'h1);
    rd32(32'h08, r); chk({tag, "_dna_hi"}, r, DNA_HI);
    rd32(32'h04, r); chk({tag, "_dna_lo"}, r, DNA_LO);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, d, a, c;
    logic        e, k;
    int unsigned t0;
    int          P, ph, idx;
    logic [7:0]  led, mask, v_p, v_n, prev_p, prev_n, stk_p, stk_n;
    logic [31:0] rw_addr [7] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h30, 32'h34, 32'h38};
    logic [31:0] rw_mask [7] = '{32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFFFFFF};
    logic [31:0] rw_mdl  [7] = '{default: 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {led_o, exp_p_dir_o, exp_n_dir_o, exp_p_dat_o},  32'h0);
    chk("reset_bus", {exp_n_dat_o, 5'h0, digital_loop, sys_ack, sys_err, sys_rdata[15:0]}, 32'h0);
    do_reset(t0);

    rd32(32'h00, r); chk("id", r, 32'h0000_0201);
    rd32(32'h00100000, r); chk("id_alias_upper_addr", r, 32'h0000_0201);
    for (int i = 0; i < 7; i++) begin
      rd32(rw_addr[i], r); chk($sformatf("reset_reg_%0h", rw_addr[i]), r, 32'h0);
    end
    wait_dna("boot", t0, 470);

    // Restart mid-shift after a fresh reset.
    do_reset(t0);
    while (int'(cyc - t0) < 199) @(posedge clk);
    #1;
    wr32(32'h0C, 32'h2);
    t0 = cyc;
    rd32(32'h08, r); chk("restart_hi_cleared", r, 32'h0);
    rd32(32'h0C, r); chk("restart_bit_reads0", r, 32'h0);
    wait_dna("restart", t0, 470);

    bus(1'b1, 32'h04, $urandom, r, e, k);
    chk("ro_write_ack", {31'h0, k}, 32'h1);
    chk("ro_write_err", {31'h0, e}, 32'h0);
    rd32(32'h04, r); chk("ro_write_ignored", r, DNA_LO);

    wr32(32'h0C, 32'h1);
    chk("digital_loop_port", {31'h0, digital_loop}, 32'h1);
    rd32(32'h0C, r); chk("digital_loop_read", r, 32'h1);

    wr32(32'h10, 32'hF0);
    wr32(32'h18, 32'h3C);
    chk("exp_p_dir_port", {24'h0, exp_p_dir_o}, 32'hF0);
    chk("exp_p_dat_port", {24'h0, exp_p_dat_o}, 32'h3C);
    rd32(32'h10, r); chk("exp_p_dir_read", r, 32'hF0);
    rd32(32'h18, r); chk("exp_p_dat_read", r, 32'h3C);
    rw_mdl[0] = 32'hF0; rw_mdl[2] = 32'h3C;

    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(0, 6);
      d = $urandom;
      wr32(rw_addr[idx], d);
      rw_mdl[idx] = d & rw_mask[idx];
      idx = $urandom_range(0, 6);
      rd32(rw_addr[idx], r);
      chk($sformatf("rw_%0h", rw_addr[idx]), r, rw_mdl[idx]);
    end
    chk("ports_after_rw", {exp_p_dir_o, exp_n_dir_o, exp_p_dat_o, exp_n_dat_o},
        {rw_mdl[0][7:0], rw_mdl[1][7:0], rw_mdl[2][7:0], rw_mdl[3][7:0]});

    // Blink: phase(k) = ((k-1)/P) mod 2, k counted from the cycle after the period write.
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin led = 8'hA5; mask = 8'h0F; P = 3; end
      else begin led = 8'($urandom); mask = 8'($urandom); P = $urandom_range(1, 5); end
      wr32(32'h30, {24'h0, led});
      wr32(32'h34, {24'h0, mask});
      wr32(32'h38, 32'(P));
      for (int kk = 1; kk <= 4 * P; kk++) begin
        ph = ((kk - 1) / P) % 2;
        chk($sformatf("blink_p%0d_k%0d", P, kk), {24'h0, led_o},
            {24'h0, led ^ (mask & (ph != 0 ? 8'hFF : 8'h00))});
        @(posedge clk); #1;
      end
    end
    wr32(32'h38, 32'h0);
    for (int kk = 0; kk < 8; kk++) begin
      chk("blink_off", {24'h0, led_o}, {24'h0, led});
      @(posedge clk); #1;
    end

    // GPIO: stable random levels; sticky accumulates rising bits between levels.
    prev_p = '0; prev_n = '0; stk_p = '0; stk_n = '0;
    for (int it = 0; it < 8; it++) begin
      v_p = 8'($urandom); v_n = 8'($urandom);
      exp_p_dat_i = v_p; exp_n_dat_i = v_n;
      stk_p |= v_p & ~prev_p; stk_n |= v_n & ~prev_n;
      prev_p = v_p; prev_n = v_n;
      repeat (3) @(posedge clk);
      #1;
      rd32(32'h20, r); chk("gpio_in_p", r, {24'h0, v_p});
      rd32(32'h24, r); chk("gpio_in_n", r, {24'h0, v_n});
      rd32(32'h28, r); chk("sticky_p", r, {24'h0, stk_p});
      rd32(32'h2C, r); chk("sticky_n", r, {24'h0, stk_n});
      c = $urandom;
      wr32(32'h28, c); stk_p &= ~c[7:0];
      wr32(32'h2C, c >> 8); stk_n &= ~c[15:8];
    end

    exp_p_dat_i = '0;
    repeat (4) @(posedge clk);
    #1;
    wr32(32'h28, 32'hFF);
    rd32(32'h28, r); chk("sticky_cleared", r, 32'h0);
    exp_p_dat_i = 8'h04;
    @(posedge clk); #1 exp_p_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rd32(32'h28, r); chk("pulse_sticky", r, 32'h4);
    wr32(32'h28, 32'h4);
    rd32(32'h28, r); chk("pulse_w1c", r, 32'h0);
    exp_p_dat_i = 8'h04;
    @(posedge clk); #1 exp_p_dat_i = 8'h00;
    wr32(32'h28, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    rd32(32'h28, r); chk("set_wins_over_clear", r, 32'h4);

    bus(1'b0, 32'h40, 32'h0, r, e, k);
    chk("unmapped_ack", {31'h0, k}, 32'h1);
    chk("unmapped_err", {31'h0, e}, 32'h1);
    chk("unmapped_rdata", r, 32'h0);
    @(posedge clk); #1;
    chk("ack_single_pulse", {31'h0, sys_ack}, 32'h0);
    for (int it = 0; it < 4; it++) begin
      a = 32'($urandom_range(16, 262143)) << 2;
      bus(it[0], a, $urandom, r, e, k);
      chk($sformatf("unmapped_%0h", a), {k, e, r[29:0]}, {2'b11, 30'h0});
    end
    bus(1'b0, 32'h30, 32'h0, r, e, k);
    chk("mapped_no_err", {30'h0, k, e}, 32'h2);

    // Reset with a read strobe pending.
    wr32(32'h30, 32'hFF);
    @(posedge clk); #1;
    rst = 1'b1; sys_ren = 1'b1; sys_addr = 32'h0;
    @(posedge clk); #1;
    chk("reset_mid_op", {led_o, 7'h0, sys_ack, sys_rdata[15:0]}, 32'h0);
    rst = 1'b0; sys_ren = 1'b0;
    @(posedge clk); #1;
    chk("ack_after_reset", {31'h0, sys_ack}, 32'h0);
    rd32(32'h30, r); chk("led_reg_after_reset", r, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
